// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: scans a 4x4 active-low key matrix and reports one debounced key code per press.
// Latency: a code is presented the clock after the tick that completes the DEBOUNCE_SCANS-th identical frame.
// Backpressure: valid/ready; an event arriving while an unaccepted code is pending is dropped and sets o_overrun.
module keypad_matrix_scanner #(
  parameter int F_CLK          = 50000000,
  parameter int F_SCAN         = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_col,
  output logic [3:0] o_row,
  output logic [3:0] o_key_code,
  output logic       o_key_valid,
  input  logic       i_key_ready,
  output logic       o_key_down,
  output logic       o_overrun
);

  // Row-step period in clocks and the counter widths derived from it.
  localparam int TP = F_CLK / F_SCAN;
  localparam int TW = (TP > 1) ? $clog2(TP) : 1;
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TP - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);
  localparam logic [SW-1:0] STABLE_ONE = SW'(1);

  // Frame classification. The code field is forced to zero unless exactly one
  // key was seen, so NONE/MULTI frames compare equal regardless of which keys.
  typedef enum logic [1:0] {
    RES_NONE  = 2'd0,
    RES_KEY   = 2'd1,
    RES_MULTI = 2'd2
  } res_kind_t;

  typedef struct packed {
    res_kind_t  kind;
    logic [3:0] code;
  } frame_res_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HELD = 1'b1
  } state_t;

  localparam frame_res_t RES_RESET = '{kind: RES_NONE, code: 4'd0};

  // ---------------------------------------------------------------------------
  // Column synchronizer
  // ---------------------------------------------------------------------------
  logic [3:0] col_meta;
  logic [3:0] col_sync;

  // Two-flop synchronizer; reset value is "nothing pressed".
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      col_meta <= 4'hF;
      col_sync <= 4'hF;
    end else begin
      col_meta <= i_col;
      col_sync <= col_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Tick divider
  // ---------------------------------------------------------------------------
  logic [TW-1:0] tick_cnt;
  logic          tick;

  assign tick = (tick_cnt == TICK_LAST);

  // Free-running 0..TP-1 counter; tick marks the last count of each row slot.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Row scan
  // ---------------------------------------------------------------------------
  logic [1:0] row_idx;
  logic [1:0] row_nxt;

  assign row_nxt = row_idx + 2'd1;

  // Each tick samples the current row, then steps the one-cold drive to the next row.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      row_idx <= 2'd0;
      o_row   <= 4'b1110;
    end else if (tick) begin
      row_idx <= row_nxt;
      o_row   <= ~(4'b0001 << row_nxt);
    end
  end

  // ---------------------------------------------------------------------------
  // Per-row decode and frame accumulation
  // ---------------------------------------------------------------------------
  logic [3:0] row_press;
  logic [2:0] row_cnt;
  logic [1:0] row_hi_col;
  logic       row_any;

  // Count pressed columns in the row being sampled; the highest pressed column is the "last" one.
  always_comb begin
    row_press  = ~col_sync;
    row_cnt    = 3'd0;
    row_hi_col = 2'd0;
    for (int c = 0; c < 4; c++) begin
      if (row_press[c]) begin
        row_cnt    = row_cnt + 3'd1;
        row_hi_col = 2'(c);
      end
    end
    row_any = |row_press;
  end

  // Accumulator only needs to distinguish 0, 1 and "more than 1", so it saturates at 2.
  logic [1:0] acc_cnt;
  logic [3:0] acc_code;
  logic [3:0] sum_cnt;
  logic [1:0] frame_cnt;
  logic [3:0] frame_code;
  logic       frame_done;
  frame_res_t frame_res;

  // Fold the current row into the running frame totals and classify on the row-3 tick.
  always_comb begin
    sum_cnt    = {2'b00, acc_cnt} + {1'b0, row_cnt};
    frame_cnt  = (sum_cnt > 4'd2) ? 2'd2 : sum_cnt[1:0];
    frame_code = row_any ? {row_idx, row_hi_col} : acc_code;
    frame_done = tick && (row_idx == 2'd3);
    frame_res  = RES_RESET;
    case (frame_cnt)
      2'd0:    frame_res.kind = RES_NONE;
      2'd1:    frame_res.kind = RES_KEY;
      default: frame_res.kind = RES_MULTI;
    endcase
    if (frame_res.kind == RES_KEY) begin
      frame_res.code = frame_code;
    end
  end

  // Accumulate across rows 0..2, clear when the frame is classified.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      acc_cnt  <= 2'd0;
      acc_code <= 4'd0;
    end else if (frame_done) begin
      acc_cnt  <= 2'd0;
      acc_code <= 4'd0;
    end else if (tick) begin
      acc_cnt  <= frame_cnt;
      acc_code <= frame_code;
    end
  end

  // ---------------------------------------------------------------------------
  // Stability counting
  // ---------------------------------------------------------------------------
  frame_res_t    prev_res;
  logic [SW-1:0] stable_cnt;
  logic [SW-1:0] stable_nxt;
  logic          deb_hit;

  // deb_hit fires only on the frame where the count first reaches the threshold,
  // so a long steady state is acted on exactly once.
  always_comb begin
    if (frame_res == prev_res) begin
      stable_nxt = (stable_cnt == STABLE_MAX) ? stable_cnt : stable_cnt + 1'b1;
    end else begin
      stable_nxt = STABLE_ONE;
    end
    deb_hit = frame_done && (stable_nxt == STABLE_MAX) && (stable_cnt != STABLE_MAX);
  end

  // Remember the previous frame and its run length once per frame.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      prev_res   <= RES_RESET;
      stable_cnt <= '0;
    end else if (frame_done) begin
      prev_res   <= frame_res;
      stable_cnt <= stable_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce FSM
  // ---------------------------------------------------------------------------
  state_t state;
  state_t state_nxt;
  logic   key_evt;

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Press is reported once on entry to HELD; only a debounced NONE releases it.
  always_comb begin
    state_nxt = state;
    key_evt   = 1'b0;
    if (deb_hit) begin
      case (state)
        S_IDLE: begin
          if (frame_res.kind == RES_KEY) begin
            state_nxt = S_HELD;
            key_evt   = 1'b1;
          end
        end
        S_HELD: begin
          if (frame_res.kind == RES_NONE) begin
            state_nxt = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Registered held indicator tracks the FSM state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_key_down <= 1'b0;
    end else begin
      o_key_down <= (state_nxt == S_HELD);
    end
  end

  // ---------------------------------------------------------------------------
  // Output handshake
  // ---------------------------------------------------------------------------
  logic key_accept;

  assign key_accept = o_key_valid & i_key_ready;

  // One-entry output slot: a new event may replace a code only as it is being accepted.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_key_valid <= 1'b0;
      o_key_code  <= 4'd0;
      o_overrun   <= 1'b0;
    end else if (key_evt) begin
      if (!o_key_valid || key_accept) begin
        o_key_valid <= 1'b1;
        o_key_code  <= frame_res.code;
      end else begin
        o_overrun <= 1'b1;
      end
    end else if (key_accept) begin
      o_key_valid <= 1'b0;
    end
  end

endmodule
